uart_xmtr: RTL and testbench

- UART transmitter that serializes host bytes into asynchronous frames on a single line: start bit, data LSB-first, stop bit(s).
- Sits directly upstream of the UART receiver; its Serial_out drives the receiver's Serial_in.
- Runs on the same Sample_clk, with one bit time equal to samples_per_bit clocks, so frames match the receiver's sampling.
- Includes a one-byte holding register, so the host can queue the next byte while the current frame is on the line.

---
 rtl/uart_xmtr.sv | 129 ++++++++++++
 tb/tb_uart_xmtr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_xmtr.sv
// UART transmitter: start bit, word_size data bits LSB-first, optional even
// parity, stop_bits stop bits. One bit time is samples_per_bit Sample_clk
// cycles. A one-entry holding register lets the host queue the next byte
// while the current frame is on the line, so frames can run back to back.
// Optional feature macro: UART_XMTR_PARITY_EN (inserts an even-parity bit
// between the data MSB and the first stop bit).
module uart_xmtr #(
  parameter int unsigned word_size       = 8,
  parameter int unsigned samples_per_bit = 8,
  parameter int unsigned stop_bits       = 1
) (
  input  logic                 Sample_clk,
  input  logic                 rst_b,
  input  logic [word_size-1:0] Data_in,
  input  logic                 Xmt_valid,
  output logic                 Xmt_ready,
  output logic                 Serial_out,
  output logic                 Busy,
  output logic                 Frame_done
);

`ifdef UART_XMTR_PARITY_EN
  localparam int unsigned frame_len = 2 + word_size + stop_bits;
`else
  localparam int unsigned frame_len = 1 + word_size + stop_bits;
`endif
  localparam int unsigned SCW = (samples_per_bit > 1) ? $clog2(samples_per_bit) : 1;
  localparam int unsigned BCW = $clog2(frame_len);
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(samples_per_bit - 1);
  localparam logic [BCW-1:0] BIT_LAST    = BCW'(frame_len - 1);

  typedef enum logic {IDLE, SENDING} state_t;

  state_t                 state_q, state_d;
  logic [word_size-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [frame_len-1:0]   shift_q, shift_d;
  logic [SCW-1:0]         sample_cnt_q, sample_cnt_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic [frame_len-1:0]   load_frame;

  // Frame image built from the holding register; bit 0 goes out first.
  always_comb begin
`ifdef UART_XMTR_PARITY_EN
    load_frame = {{stop_bits{1'b1}}, ^hold_q, hold_q, 1'b0};
`else
    load_frame = {{stop_bits{1'b1}}, hold_q, 1'b0};
`endif
  end

  // Next-state logic: host capture into hold, frame sequencing and shifting.
  // Capture needs hold empty and transfer needs hold full, so they never collide.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;

    if (Xmt_valid && !hold_full_q) begin
      hold_d      = Data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d      = load_frame;
          hold_full_d  = 1'b0;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          state_d      = SENDING;
        end
      end
      SENDING: begin
        if (sample_cnt_q != SAMPLE_LAST) begin
          sample_cnt_d = sample_cnt_q + SCW'(1);
        end else begin
          sample_cnt_d = '0;
          if (bit_cnt_q != BIT_LAST) begin
            shift_d   = {1'b1, shift_q[frame_len-1:1]};
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end else begin
            frame_done_d = 1'b1;
            bit_cnt_d    = '0;
            if (hold_full_q) begin
              shift_d     = load_frame;
              hold_full_d = 1'b0;
            end else begin
              shift_d = '1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset forces the line high immediately via the shifter.
  always_ff @(posedge Sample_clk or posedge rst_b) begin
    if (rst_b) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '1;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Serial_out = shift_q[0];
  assign Xmt_ready  = ~hold_full_q;
  assign Busy       = (state_q == SENDING) | hold_full_q;
  assign Frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_xmtr.sv
// Bench for uart_xmtr: directed and random bytes checked every cycle against
// a timeline model (frame start edges per accepted byte) of the serial line.
module tb_uart_xmtr;

  localparam int unsigned WS  = 8;
  localparam int unsigned SPB = 8;
  localparam int unsigned SB  = 1;
`ifdef UART_XMTR_PARITY_EN
  localparam int unsigned FL = WS + SB + 2;
`else
  localparam int unsigned FL = WS + SB + 1;
`endif
  localparam int unsigned FLEN = FL * SPB;

  logic          clk;
  logic          rst;
  logic [WS-1:0] Data_in;
  logic          Xmt_valid;
  logic          Xmt_ready;
  logic          Serial_out;
  logic          Busy;
  logic          Frame_done;

  uart_xmtr #(
    .word_size(WS),
    .samples_per_bit(SPB),
    .stop_bits(SB)
  ) dut (
    .Sample_clk(clk),
    .rst_b(rst),
    .Data_in(Data_in),
    .Xmt_valid(Xmt_valid),
    .Xmt_ready(Xmt_ready),
    .Serial_out(Serial_out),
    .Busy(Busy),
    .Frame_done(Frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  int unsigned   cyc = 0;
  int unsigned   hold_busy_until = 0;
  int unsigned   fstart[$];
  logic [WS-1:0] fbyte[$];
  logic [WS-1:0] host_q[$];

  // Expected bit number idx of the frame carrying byte b.
  function automatic logic exp_bit(logic [WS-1:0] b, int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= WS) return b[idx-1];
`ifdef UART_XMTR_PARITY_EN
    if (idx == WS + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic int unsigned cur_end();
    if (fstart.size() == 0) return 0;
    return fstart[fstart.size()-1] + FLEN;
  endfunction

  task automatic chk(string tag, logic obs, logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all();
    logic e_ser, e_done, e_busy, e_rdy;
    e_ser  = 1'b1;
    e_done = 1'b0;
    e_rdy  = (cyc >= hold_busy_until);
    e_busy = !e_rdy;
    for (int i = 0; i < fstart.size(); i++) begin
      if (cyc >= fstart[i] && cyc < fstart[i] + FLEN) begin
        e_ser  = exp_bit(fbyte[i], (cyc - fstart[i]) / SPB);
        e_busy = 1'b1;
      end
      if (cyc == fstart[i] + FLEN) e_done = 1'b1;
    end
    chk("serial_out", Serial_out, e_ser);
    chk("frame_done", Frame_done, e_done);
    chk("busy",       Busy,       e_busy);
    chk("xmt_ready",  Xmt_ready,  e_rdy);
  endtask

  // One clock: check at the falling edge, drive, then apply the accept rule.
  task automatic cycle();
    logic        rdy;
    int unsigned s;
    check_all();
    rdy = (cyc >= hold_busy_until);
    if (host_q.size() > 0) begin
      Xmt_valid = 1'b1;
      Data_in   = host_q[0];
    end else begin
      Xmt_valid = 1'b0;
      Data_in   = WS'($urandom);
    end
    @(posedge clk);
    cyc++;
    if (Xmt_valid && rdy) begin
      s = (cyc + 1 > cur_end()) ? cyc + 1 : cur_end();
      fstart.push_back(s);
      fbyte.push_back(Data_in);
      hold_busy_until = s;
      void'(host_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run(int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int unsigned k;
    logic        timed_out;
    k = 0;
    while ((host_q.size() != 0 || cyc <= cur_end() + 1) && k < 3000) begin
      cycle();
      k++;
    end
    timed_out = (k >= 3000);
    chk("drain_timeout", timed_out, 1'b0);
  endtask

  initial begin
    int unsigned k;
    int unsigned s0;
    rst       = 1'b1;
    Xmt_valid = 1'b0;
    Data_in   = '0;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Idle after reset
    run(20);

    // Single byte 0xA5
    host_q.push_back(8'hA5);
    drain();

    // 0x3C, then 0xC3 presented 20 cycles into the frame -> back-to-back
    host_q.push_back(8'h3C);
    run(21);
    host_q.push_back(8'hC3);
    drain();

    // Host holds valid through 0x11, 0x22, 0x33 while hold is full
    host_q.push_back(8'h11);
    host_q.push_back(8'h22);
    host_q.push_back(8'h33);
    drain();

    // Reset 35 cycles into a 0x00 frame (line low), then 0x5A
    host_q.push_back(8'h00);
    run(1);
    s0 = (fstart.size() > 0) ? fstart[fstart.size()-1] : 0;
    k = 0;
    while (cyc < s0 + 34 && k < 200) begin
      cycle();
      k++;
    end
    check_all();
    Xmt_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    fstart.delete();
    fbyte.delete();
    host_q.delete();
    hold_busy_until = 0;
    check_all();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
    rst = 1'b0;
    run(5);
    host_q.push_back(8'h5A);
    drain();

    // Loopback-style bytes and parity example
    host_q.push_back(8'h00);
    host_q.push_back(8'hFF);
    host_q.push_back(8'h5A);
    host_q.push_back(8'h07);
    drain();

    // Random bytes with random host gaps
    for (int i = 0; i < 30; i++) begin
      host_q.push_back(WS'($urandom));
      run($urandom_range(0, 100));
    end
    drain();
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
